// File: rtl/neural_packet_queue_framer_if.sv
// Stream bundle for neural_packet_queue_framer: the acquisition sample side,
// the channel mask, the packet stream with backpressure, and the status/drop counters.
// master = the environment (acquisition source and packet sink), slave = the framer.
interface neural_packet_queue_framer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int CH_ID_WIDTH = 4,
    parameter int TS_WIDTH    = 32,
    parameter int SEQ_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 8
);
    localparam int NUM_CH       = 2 ** CH_ID_WIDTH;
    localparam int PACKET_WIDTH = TS_WIDTH + SEQ_WIDTH + CH_ID_WIDTH + DATA_WIDTH + 4;
    localparam int LEVEL_WIDTH  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0]   acq_data;
    logic [CH_ID_WIDTH-1:0]  acq_channel;
    logic                    acq_valid;
    logic [NUM_CH-1:0]       ch_enable;
    logic [PACKET_WIDTH-1:0] pkt_data;
    logic                    pkt_valid;
    logic                    pkt_ready;
    logic [LEVEL_WIDTH-1:0]  fifo_level;
    logic [15:0]             drop_count;
    logic                    drop_clear;

    modport master (
        output acq_data, acq_channel, acq_valid, ch_enable, pkt_ready, drop_clear,
        input  pkt_data, pkt_valid, fifo_level, drop_count
    );

    modport slave (
        input  acq_data, acq_channel, acq_valid, ch_enable, pkt_ready, drop_clear,
        output pkt_data, pkt_valid, fifo_level, drop_count
    );
endinterface

// File: rtl/neural_packet_queue_framer.sv
// neural_packet_queue_framer: stamps accepted samples with a free-running
// timestamp and sequence number, packs {ts, seq, ch, data, flags} and queues
// packets in a FIFO delivered on a valid/ready stream.
// Optional feature macro: NPQF_PARITY_EN (even parity over the packet in flags[0]).
module neural_packet_queue_framer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CH_ID_WIDTH = 4,
    parameter int TS_WIDTH    = 32,
    parameter int SEQ_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input logic sensor_clk,
    input logic sensor_rst,
    neural_packet_queue_framer_if.slave bus
);
    localparam int PACKET_WIDTH = TS_WIDTH + SEQ_WIDTH + CH_ID_WIDTH + DATA_WIDTH + 4;
    localparam int PTR_WIDTH    = $clog2(FIFO_DEPTH);

    // Control state
    logic [TS_WIDTH-1:0]  ts_cnt;
    logic [SEQ_WIDTH-1:0] seq_cnt;
    logic                 pending_drop;
    logic                 pending_wrap;
    logic [15:0]          drop_cnt;
    logic [PTR_WIDTH:0]   wr_ptr;
    logic [PTR_WIDTH:0]   rd_ptr;

    // Packet storage (data only, never reset; the head mux hides stale entries)
    logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                    empty;
    logic                    full;
    logic                    accept;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    wrap_now;
    logic [PACKET_WIDTH-2:0] pkt_body;
    logic [PACKET_WIDTH-1:0] pkt_word;

    // Saturating increment for the drop counter
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

`ifdef NPQF_PARITY_EN
    // Even parity: the stored bit makes the whole packet XOR to zero
    function automatic logic parity_bit(input logic [PACKET_WIDTH-2:0] body);
        return ^body;
    endfunction
`endif

    // Handshake and qualification terms; pkt_ready only reaches the push side via the full-with-pop case
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
        accept   = bus.acq_valid && bus.ch_enable[bus.acq_channel];
        pop      = !empty && bus.pkt_ready;
        push     = accept && (!full || pop);
        drop     = accept && full && !pop;
        wrap_now = &ts_cnt;
        // A wrap on the same edge as the write is reported in this packet
        pkt_body = {ts_cnt, seq_cnt, bus.acq_channel, bus.acq_data,
                    pending_drop, pending_wrap | wrap_now, 1'b0};
`ifdef NPQF_PARITY_EN
        pkt_word = {pkt_body, parity_bit(pkt_body)};
`else
        pkt_word = {pkt_body, 1'b0};
`endif
    end

    // Timestamp, sequence, pending flags, drop counter and FIFO pointers
    always_ff @(posedge sensor_clk) begin
        if (sensor_rst) begin
            ts_cnt       <= '0;
            seq_cnt      <= '0;
            pending_drop <= 1'b0;
            pending_wrap <= 1'b0;
            drop_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (push) begin
                wr_ptr       <= wr_ptr + (PTR_WIDTH + 1)'(1);
                seq_cnt      <= seq_cnt + SEQ_WIDTH'(1);
                pending_drop <= 1'b0;
                pending_wrap <= 1'b0;
            end else begin
                if (drop) begin
                    pending_drop <= 1'b1;
                end
                if (wrap_now) begin
                    pending_wrap <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_WIDTH + 1)'(1);
            end
            if (bus.drop_clear) begin
                drop_cnt <= '0;
            end else if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge sensor_clk) begin
        if (push) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= pkt_word;
        end
    end

    // Head of FIFO and status outputs; an empty FIFO presents an all-zero packet
    always_comb begin
        bus.pkt_valid  = !empty;
        bus.pkt_data   = empty ? '0 : mem[rd_ptr[PTR_WIDTH-1:0]];
        bus.fifo_level = wr_ptr - rd_ptr;
        bus.drop_count = drop_cnt;
    end
endmodule

// File: tb/tb_neural_packet_queue_framer.sv
// Testbench for neural_packet_queue_framer with an 8-bit timestamp so that
// rollover is reachable; a queue-based reference model predicts every cycle.
module tb_neural_packet_queue_framer;
    localparam int DW      = 16;
    localparam int CW      = 4;
    localparam int TW      = 8;
    localparam int SW      = 8;
    localparam int DEPTH   = 8;
    localparam int PW      = TW + SW + CW + DW + 4;
    localparam int SEQ_LSB = DW + CW + 4;
    localparam int TS_MAX  = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neural_packet_queue_framer_if #(
        .DATA_WIDTH(DW), .CH_ID_WIDTH(CW), .TS_WIDTH(TW), .SEQ_WIDTH(SW), .FIFO_DEPTH(DEPTH)
    ) bus ();

    neural_packet_queue_framer #(
        .DATA_WIDTH(DW), .CH_ID_WIDTH(CW), .TS_WIDTH(TW), .SEQ_WIDTH(SW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sensor_clk(clk),
        .sensor_rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [PW-1:0] q[$];
    int ts_m, seq_m, dc_m;
    bit pd_m, pw_m;

    function automatic logic [PW-1:0] make_pkt(int ts, int seq, logic [CW-1:0] ch,
                                               logic [DW-1:0] d, bit df, bit wf);
        logic [PW-2:0] body;
        body = {TW'(ts), SW'(seq), ch, d, df, wf, 1'b0};
`ifdef NPQF_PARITY_EN
        return {body, ^body};
`else
        return {body, 1'b0};
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model predicts from pre-edge inputs, then outputs are compared after the edge
    task automatic step();
        bit acc, pop, full, wrap_now;
        if (rst) begin
            q.delete();
            ts_m = 0; seq_m = 0; dc_m = 0; pd_m = 0; pw_m = 0;
        end else begin
            acc      = bus.acq_valid && bus.ch_enable[bus.acq_channel];
            pop      = (q.size() > 0) && bus.pkt_ready;
            full     = (q.size() == DEPTH);
            wrap_now = (ts_m == TS_MAX);
            if (pop) void'(q.pop_front());
            if (acc && (!full || pop)) begin
                q.push_back(make_pkt(ts_m, seq_m, bus.acq_channel, bus.acq_data, pd_m, pw_m || wrap_now));
                seq_m = (seq_m + 1) % (1 << SW);
                pd_m  = 0;
                pw_m  = 0;
            end else begin
                if (acc) begin
                    pd_m = 1;
                    if (dc_m < 65535) dc_m++;
                end
                if (wrap_now) pw_m = 1;
            end
            if (bus.drop_clear) dc_m = 0;
            ts_m = (ts_m + 1) % (1 << TW);
        end
        @(posedge clk);
        #1;
        chk("pkt_valid", 64'(bus.pkt_valid), 64'(q.size() != 0));
        chk("pkt_data", 64'(bus.pkt_data), (q.size() != 0) ? 64'(q[0]) : 64'd0);
        chk("fifo_level", 64'(bus.fifo_level), 64'(q.size()));
        chk("drop_count", 64'(bus.drop_count), 64'(dc_m));
    endtask

    task automatic set_in(input bit v, input logic [CW-1:0] ch, input logic [DW-1:0] d,
                          input bit rdy);
        bus.acq_valid   = v;
        bus.acq_channel = ch;
        bus.acq_data    = d;
        bus.pkt_ready   = rdy;
    endtask

    initial begin
        logic [PW-1:0] exp1;
        rst            = 1'b1;
        bus.ch_enable  = '1;
        bus.drop_clear = 1'b0;
        set_in(0, 0, 0, 0);
        step();

        // First packet: ch 3, data ABCD accepted at timestamp 5
        rst = 1'b0;
        set_in(0, 0, 0, 1);
        repeat (5) step();
        set_in(1, 4'h3, 16'hABCD, 1);
        step();
        exp1 = {8'd5, 8'd0, 4'h3, 16'hABCD, 4'b0000};
`ifdef NPQF_PARITY_EN
        exp1[0] = ^exp1[PW-1:1];
        chk("first_parity_even", 64'(^bus.pkt_data), 64'd0);
`endif
        chk("first_packet", 64'(bus.pkt_data), 64'(exp1));
        chk("first_level", 64'(bus.fifo_level), 64'd1);
        set_in(0, 0, 0, 1);
        step();

        // Overflow: 10 samples into 8 entries with no ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, CW'($urandom), DW'($urandom), 0);
            step();
        end
        chk("ovf_level", 64'(bus.fifo_level), 64'd8);
        chk("ovf_drops", 64'(bus.drop_count), 64'd2);
        // Full with a simultaneous pop: written, not dropped
        set_in(1, CW'($urandom), DW'($urandom), 1);
        step();
        chk("full_pop_level", 64'(bus.fifo_level), 64'd8);
        chk("full_pop_drops", 64'(bus.drop_count), 64'd2);
        set_in(0, 0, 0, 1);
        repeat (7) step();
        chk("ninth_seq", 64'(bus.pkt_data[SEQ_LSB +: SW]), 64'd8);
        chk("ninth_drop_flag", 64'(bus.pkt_data[3]), 64'd1);
        repeat (2) step();

        // drop_clear wins over a same-cycle drop
        for (int i = 0; i < 9; i++) begin
            set_in(1, CW'($urandom), DW'($urandom), 0);
            step();
        end
        bus.drop_clear = 1'b1;
        step();
        bus.drop_clear = 1'b0;
        chk("clear_priority", 64'(bus.drop_count), 64'd0);
        set_in(0, 0, 0, 1);
        repeat (9) step();

        // Disabled channel 5 is ignored
        bus.ch_enable[5] = 1'b0;
        set_in(1, 4'd5, 16'h1234, 1);
        step();
        chk("disabled_level", 64'(bus.fifo_level), 64'd0);
        bus.ch_enable = '1;

        // Timestamp rollover with back-to-back writes
        set_in(0, 0, 0, 1);
        while (ts_m != TS_MAX - 1) step();
        set_in(1, 4'd1, 16'h0001, 1);
        step();
        set_in(1, 4'd1, 16'h0002, 1);
        step();
        chk("wrap_same_cycle", 64'(bus.pkt_data[2]), 64'd1);
        set_in(1, 4'd1, 16'h0003, 1);
        step();
        chk("wrap_after", 64'(bus.pkt_data[2]), 64'd0);

        // Rollover while idle, flagged on the next write only
        set_in(0, 0, 0, 1);
        while (ts_m != TS_MAX) step();
        step();
        while (ts_m != 10) step();
        set_in(1, 4'd2, 16'h00AA, 1);
        step();
        chk("wrap_pending", 64'(bus.pkt_data[2]), 64'd1);
        set_in(1, 4'd2, 16'h00BB, 1);
        step();
        chk("wrap_cleared", 64'(bus.pkt_data[2]), 64'd0);

        // 300 streaming writes: sequence wraps
        for (int i = 0; i < 300; i++) begin
            set_in(1, CW'($urandom), DW'($urandom), 1);
            step();
        end

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            bus.ch_enable  = 16'($urandom | $urandom);
            bus.drop_clear = ($urandom_range(0, 15) == 0);
            set_in($urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom),
                   $urandom_range(0, 2) == 0);
            step();
        end
        bus.ch_enable  = '1;
        bus.drop_clear = 1'b0;
        set_in(0, 0, 0, 1);
        repeat (9) step();

        // Reset with 4 packets queued
        for (int i = 0; i < 4; i++) begin
            set_in(1, CW'($urandom), DW'($urandom), 0);
            step();
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        step();
        chk("rst_valid", 64'(bus.pkt_valid), 64'd0);
        chk("rst_level", 64'(bus.fifo_level), 64'd0);
        chk("rst_drops", 64'(bus.drop_count), 64'd0);
        rst = 1'b0;
        set_in(1, 4'd7, 16'h5A5A, 0);
        step();
        chk("rst_seq0", 64'(bus.pkt_data[SEQ_LSB +: SW]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/neural_packet_queue_framer.md
# neural_packet_queue_framer

Parametrised successor framer for the sensor acquisition pipeline. Accepts channel-tagged samples from the acquisition stage, stamps each with a free-running timestamp and a sequence number, and assembles a flagged packet. Packets are buffered in an internal FIFO and delivered on a valid/ready stream, so the downstream link can apply backpressure. Overflow is counted, and loss or timestamp wrap is flagged in the next delivered packet.

## Interface
- DATA_WIDTH, 16, sample width
- CH_ID_WIDTH, 4, channel id width; NUM_CH = 2**CH_ID_WIDTH
- TS_WIDTH, 32, timestamp counter width
- SEQ_WIDTH, 8, sequence number width
- FIFO_DEPTH, 8, packet buffer entries (power of 2, >= 2)
- Derived PACKET_WIDTH = TS_WIDTH+SEQ_WIDTH+CH_ID_WIDTH+DATA_WIDTH+4 (64 at defaults)
- sensor_clk  in  1  single clock; all logic is on its rising edge
- sensor_rst  in  1  synchronous, active-high reset
- acq_data  in  DATA_WIDTH  sample
- acq_channel  in  CH_ID_WIDTH  sample channel id
- acq_valid  in  1  sample strobe; no backpressure toward acquisition
- ch_enable  in  NUM_CH  per-channel accept mask
- pkt_data  out  PACKET_WIDTH  FIFO head packet
- pkt_valid  out  1  FIFO non-empty
- pkt_ready  in  1  downstream accept
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- drop_count  out  16  saturating count of dropped samples
- drop_clear  in  1  zeroes drop_count

## Operation
- Packet layout, MSB first: {timestamp, seq, channel, data, flags[3:0]}.
  - flags[3] = drop: one or more samples were dropped since the previous accepted packet.
  - flags[2] = ts_wrap: the timestamp wrapped since the previous accepted packet.
  - flags[1] = 0.
  - flags[0] = parity (see Configuration).
- Timestamp counter:
  - Increments by 1 every cycle and wraps modulo 2**TS_WIDTH.
  - A packet carries the counter value from the cycle its sample was accepted.
- Sample accept condition: acq_valid && ch_enable[acq_channel].
  - Disabled channel: sample ignored silently; no drop, no seq advance.
- Push:
  - An accepted sample is written when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped.
- Sequence number:
  - Increments per written packet and wraps modulo 2**SEQ_WIDTH.
  - The first packet after reset carries seq 0.
- Drop handling:
  - Increment drop_count, saturating at 0xFFFF, and set pending_drop.
  - The next written packet carries flags[3]=1, and pending_drop clears.
  - A drop in the same cycle as a write cannot occur, because there is only one sample per cycle.
- pending_wrap:
  - Set when the timestamp counter rolls from all-ones to 0.
  - Copied into flags[2] of the next written packet, then cleared.
  - Wrap and write in the same cycle: the written packet takes flags[2]=1 and pending_wrap stays clear.
- drop_clear:
  - Zeroes drop_count next cycle. It has priority over a simultaneous increment.
  - It does not affect pending_drop.
- Pop: pkt_valid && pkt_ready removes the head entry. pkt_data must stay stable while pkt_valid && !pkt_ready.
- Reset:
  - Clears the timestamp, seq, FIFO pointers, pending flags and drop_count.
  - Any packets in flight are discarded.
  - Reset values: pkt_valid=0, pkt_data=0, fifo_level=0, drop_count=0.

## Timing
- Write latency: sample accepted at edge N appears at the FIFO head, with pkt_valid=1, after edge N when the FIFO was empty. First visible cycle is N+1.
- Pop at edge M: the next entry, or pkt_valid=0, is visible after M.
- fifo_level updates on the same edge as push/pop; simultaneous push and pop leaves it unchanged.
- Full throughput: one packet per cycle when pkt_ready is held high.
- pkt_data is driven from FIFO storage, i.e. registered, with no combinational path from acq_* to pkt_*.
- pkt_ready has no combinational path to acq-side logic other than the full-with-pop push qualification.

## Configuration
- NPQF_PARITY_EN defined:
  - flags[0] = XOR of all other PACKET_WIDTH-1 bits, giving even parity over the whole packet.
  - Computed at write time and stored in the FIFO.
- NPQF_PARITY_EN undefined: flags[0] is tied to 0 and no parity logic is built.

## Test plan
- Reset, then ch_enable=all ones, pkt_ready=1, one sample (ch 3, data 0xABCD) accepted when timestamp=5 -> next cycle pkt_data={32'd5, 8'd0, 4'h3, 16'hABCD, flags}, pkt_valid=1, fifo_level=1; with parity on, popcount(pkt_data) is even.
- pkt_ready=0, 10 back-to-back samples into FIFO_DEPTH=8 -> fifo_level=8, drop_count=2; after draining, the 9th written packet has flags[3]=1 and seq 8.
- FIFO full, a sample and pkt_ready=1 in the same cycle -> sample written, no drop, fifo_level stays 8.
- ch_enable[5]=0, sample on ch 5 -> no packet, seq and drop_count unchanged.
- Force the timestamp near wrap with TS_WIDTH=8 -> the first packet after the rollover has flags[2]=1, the following packet has flags[2]=0; 300 writes -> seq wraps 255->0.
- sensor_rst asserted with 4 packets queued -> next cycle pkt_valid=0, fifo_level=0, drop_count=0; the next sample carries seq 0.
